sequence_checker: RTL
=====================

# sequence_checker

Player-input side of the Simon Says game: after the LED blinker has played a pattern out of pattern memory, this block reads the same memory back entry by entry and compares each entry against debounced player button presses. It reports pass or fail for the round. Causes of failure are a wrong button, several buttons pressed together, or a per-press timeout. The game controller sits above it; the pattern ROM/RAM is shared with the blinker.

## Interface
- `SEQ_LEN`, 4'd5: maximum pattern length; memory entries 0..SEQ_LEN-1.
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable cycles needed before a button level is accepted. Must be ≥1; 1 is used in simulation.
- `TIMEOUT_CYCLES`, 32'd100_000_000: cycles allowed in WAIT_PRESS before the round fails. Must be ≥1.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a round; sampled only in IDLE.
- `round_len`  in  4  number of entries to check; sampled with `start`.
- `btn_n`  in  4  raw player buttons, active-low, asynchronous.
- `mem_addr`  out  4  pattern-memory read address.
- `mem_data`  in  2  button index (0..3) at `mem_addr`; valid one cycle after `mem_addr` changes (synchronous read).
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at round end.
- `pass`  out  1  round result; held until the next accepted `start`.
- `fail`  out  1  round result; held until the next accepted `start`.
- `progress`  out  4  count of correct presses in the current round.

## Operation
- Input path: `btn_n` is inverted, then passed through a 2-FF synchronizer, giving `sync[3:0]`. A whole-vector debounce follows: `deb` takes the value of `sync` once `sync` has been unchanged for `DEBOUNCE_CYCLES` consecutive cycles, and any change restarts the count.
- Press event: `deb` goes from 4'b0000 to a nonzero value. It is evaluated only in WAIT_PRESS.
- FSM states:
  - **IDLE**
    - `start`=1 with `round_len`=0: go to RESULT with pass.
    - `start`=1 otherwise: set `len` = min(`round_len`, `SEQ_LEN`), `idx`=0, `mem_addr`=0, `progress`=0; clear `pass`/`fail`; go to FETCH.
  - **FETCH**
    - One cycle for memory latency; go to LATCH.
  - **LATCH**
    - `expected` <= `mem_data`; clear the timeout counter; go to WAIT_PRESS.
  - **WAIT_PRESS**
    - A press event with `deb` == one-hot(`expected`): go to WAIT_RELEASE.
    - A press event with any other value, including multiple bits set: go to RESULT with fail.
    - The timeout counter reaches `TIMEOUT_CYCLES`: go to RESULT with fail.
    - A press event takes priority over a timeout in the same cycle.
  - **WAIT_RELEASE**
    - Wait for `deb`==0, then `progress`++.
    - If `idx`==`len`-1: go to RESULT with pass.
    - Otherwise `idx`++, `mem_addr`++, go to FETCH.
  - **RESULT**
    - Assert `done` for one cycle; set `pass` or `fail`; go to IDLE.
- A button already held when WAIT_PRESS is entered produces no event until it is released and pressed again.
- `start` while not in IDLE is ignored.
- `pass` and `fail` are never both 1.

## Timing
- Reset values: `mem_addr`=0, `busy`=0, `done`=0, `pass`=0, `fail`=0, `progress`=0, FSM in IDLE, `deb`=0, synchronizers=0.
- `reset` mid-round returns to IDLE immediately and asynchronously. The round is abandoned and no `done` is issued.
- `mem_addr` is 0 in the cycle after `start`. `mem_data` is latched 2 cycles after each `mem_addr` update.
- Pin-to-`deb` latency is between 2+`DEBOUNCE_CYCLES` and 3+`DEBOUNCE_CYCLES` cycles. Pulses shorter than `DEBOUNCE_CYCLES` cycles never reach `deb`.
- A wrong press gives `done`/`fail` 2 cycles after `deb` changes (WAIT_PRESS→RESULT, then the output register).
- A timeout gives `done`/`fail` `TIMEOUT_CYCLES`+2 cycles after WAIT_PRESS is entered.
- `round_len`=0 gives `done`/`pass` 2 cycles after `start`.
- `round_len`>`SEQ_LEN` is clamped; at most `SEQ_LEN` presses are checked.

## Test plan
- **Correct round:** memory {2,0,3,1,1}, `round_len`=3, `DEBOUNCE_CYCLES`=1; press 2, 0, 3 with releases -> `mem_addr` steps 0,1,2; one `done` pulse; `pass`=1, `fail`=0, `progress`=3; `busy` falls with `done`.
- **Wrong button:** same memory, press button 1 first -> `done` plus `fail`=1, `progress`=0, `mem_addr`=0; a following `start` clears `fail`.
- **Simultaneous press:** buttons 2 and 3 pressed together for entry 0 -> `fail`=1 with no further `mem_addr` increments.
- **Timeout:** `TIMEOUT_CYCLES`=50, no presses -> `done`/`fail` exactly 52 cycles after WAIT_PRESS entry. A correct press at cycle 49 instead advances to entry 1.
- **Reset mid-round:** assert `reset` after 2 correct presses of a 5-entry round -> all outputs 0 immediately and no `done`. `start` pulses during `busy` in a separate run are ignored.
- **Debounce and boundaries:**
  - With `DEBOUNCE_CYCLES`=8, a 5-cycle glitch on `btn_n[1]` -> no event.
  - `round_len`=0 -> `pass` 2 cycles after `start`.
  - `round_len`=9 -> exactly 5 entries checked.

Source files
------------

// File: rtl/sequence_checker.sv
// Purpose: checks debounced player presses against the pattern memory and reports pass/fail per round.
// Latency: wrong press -> done/fail 2 cycles after deb changes; timeout -> TIMEOUT_CYCLES+2 after WAIT_PRESS entry.
// Backpressure: none; the player's pace sets the rate and start is ignored while a round is running.
module sequence_checker #(
  parameter logic [3:0]  SEQ_LEN         = 4'd5,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] round_len,
  input  logic [3:0] btn_n,
  output logic [3:0] mem_addr,
  input  logic [1:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [3:0] progress
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, WAIT_PRESS, WAIT_RELEASE, RESULT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  sync1, sync, sync_d, deb, deb_d;
  logic [15:0] db_cnt;
  logic [3:0]  len, len_n, idx, idx_n, addr_n, prog_n;
  logic [1:0]  expected, exp_n;
  logic [31:0] tcnt, tcnt_n;
  logic        busy_n, done_n, pass_n, fail_n, win, win_n;
  logic        press_evt;
  logic [3:0]  exp_hot;

  // Two-flop synchroniser on the inverted (active-high) buttons.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b0;
      sync  <= 4'b0;
    end else begin
      sync1 <= ~btn_n;
      sync  <= sync1;
    end
  end

  // Whole-vector debounce: any change in sync restarts the stability count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_d <= 4'b0;
      db_cnt <= 16'd0;
      deb    <= 4'b0;
      deb_d  <= 4'b0;
    end else begin
      sync_d <= sync;
      deb_d  <= deb;
      if (sync != sync_d)
        db_cnt <= 16'd1;
      else if (db_cnt < DEBOUNCE_CYCLES)
        db_cnt <= db_cnt + 16'd1;
      if ((sync == sync_d) && (db_cnt >= DEBOUNCE_CYCLES))
        deb <= sync;
    end
  end

  // A press is only the idle-to-pressed edge, so a button held on entry is not an event.
  assign press_evt = (deb_d == 4'b0) && (deb != 4'b0);
  assign exp_hot   = 4'b0001 << expected;

  // State and datapath registers; all outputs come straight from flops.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len      <= 4'd0;
      idx      <= 4'd0;
      mem_addr <= 4'd0;
      expected <= 2'd0;
      tcnt     <= 32'd0;
      progress <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      win      <= 1'b0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      idx      <= idx_n;
      mem_addr <= addr_n;
      expected <= exp_n;
      tcnt     <= tcnt_n;
      progress <= prog_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      fail     <= fail_n;
      win      <= win_n;
    end
  end

  // Next-state and next-output logic; win holds the pending result until RESULT publishes it.
  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    addr_n  = mem_addr;
    exp_n   = expected;
    tcnt_n  = tcnt;
    prog_n  = progress;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    fail_n  = fail;
    win_n   = win;
    case (state)
      IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          pass_n = 1'b0;
          fail_n = 1'b0;
          idx_n  = 4'd0;
          addr_n = 4'd0;
          prog_n = 4'd0;
          if (round_len == 4'd0) begin
            win_n   = 1'b1;
            state_n = RESULT;
          end else begin
            len_n   = (round_len > SEQ_LEN) ? SEQ_LEN : round_len;
            state_n = FETCH;
          end
        end
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        exp_n   = mem_data;
        tcnt_n  = 32'd0;
        state_n = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (press_evt) begin
          if (deb == exp_hot) begin
            state_n = WAIT_RELEASE;
          end else begin
            win_n   = 1'b0;
            state_n = RESULT;
          end
        end else if (tcnt == TIMEOUT_CYCLES) begin
          win_n   = 1'b0;
          state_n = RESULT;
        end else begin
          tcnt_n = tcnt + 32'd1;
        end
      end
      WAIT_RELEASE: begin
        if (deb == 4'b0) begin
          prog_n = progress + 4'd1;
          if (idx == len - 4'd1) begin
            win_n   = 1'b1;
            state_n = RESULT;
          end else begin
            idx_n   = idx + 4'd1;
            addr_n  = mem_addr + 4'd1;
            state_n = FETCH;
          end
        end
      end
      RESULT: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        pass_n  = win;
        fail_n  = ~win;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
